// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for a 4-digit multiplexed hex display, with a minimum hold time before preemption.
// Optional macro SEG_LZ_BLANK_EN: blank leading-zero digits while a requester owns the display.
module seg_display_arbiter #(
  parameter int HOLD_TICKS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [3:0]  sel,
  output logic [3:0]  digit,
  output logic        blank
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_hold_cnt;
  logic        r_last_b;
  logic [1:0]  r_scan;
  logic        r_gnt_a;
  logic        r_gnt_b;
  logic [3:0]  r_sel;
  logic [3:0]  r_digit;
  logic        r_blank;
  logic        w_hold_done;
  logic [15:0] w_owner_data;

  function automatic logic [3:0] nibble_at(input logic [15:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble_at = d[15:12];
      2'd1:    nibble_at = d[11:8];
      2'd2:    nibble_at = d[7:4];
      default: nibble_at = d[3:0];
    endcase
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // A digit is dark when it and every digit to its left are zero; the last digit always shows.
  function automatic logic lz_blank(input logic [15:0] d, input logic [1:0] idx);
    case (idx)
      2'd0:    lz_blank = (d[15:12] == 4'h0);
      2'd1:    lz_blank = (d[15:8] == 8'h00);
      2'd2:    lz_blank = (d[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
  endfunction
`endif

  assign w_hold_done  = (r_hold_cnt == 16'(HOLD_TICKS));
  assign w_owner_data = (w_next == OWN_B) ? data_b : data_a;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && req_b)  w_next = r_last_b ? OWN_A : OWN_B;
        else if (req_a)      w_next = OWN_A;
        else if (req_b)      w_next = OWN_B;
      end
      OWN_A: begin
        if (!req_a)                     w_next = req_b ? OWN_B : IDLE;
        else if (w_hold_done && req_b)  w_next = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                     w_next = req_a ? OWN_A : IDLE;
        else if (w_hold_done && req_a)  w_next = OWN_A;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_hold_cnt <= 16'd0;
      r_scan     <= 2'd0;
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_sel      <= 4'b0000;
      r_digit    <= 4'h0;
      r_blank    <= 1'b1;
    end else begin
      r_state <= w_next;
      r_gnt_a <= (w_next == OWN_A);
      r_gnt_b <= (w_next == OWN_B);
      if (w_next == OWN_A)      r_last_b <= 1'b0;
      else if (w_next == OWN_B) r_last_b <= 1'b1;
      if (w_next != r_state)
        r_hold_cnt <= 16'd0;
      else if (r_state != IDLE && scan_tick && !w_hold_done)
        r_hold_cnt <= r_hold_cnt + 16'd1;
      if (scan_tick) r_scan <= r_scan + 2'd1;
      // Display outputs follow the incoming owner so a switch never shows stale data.
      if (w_next == IDLE) begin
        r_sel   <= 4'b0000;
        r_digit <= 4'h0;
        r_blank <= 1'b1;
      end else begin
        r_sel   <= 4'b1000 >> r_scan;
        r_digit <= nibble_at(w_owner_data, r_scan);
`ifdef SEG_LZ_BLANK_EN
        r_blank <= lz_blank(w_owner_data, r_scan);
`else
        r_blank <= 1'b0;
`endif
      end
    end
  end

  assign gnt_a = r_gnt_a;
  assign gnt_b = r_gnt_b;
  assign sel   = r_sel;
  assign digit = r_digit;
  assign blank = r_blank;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: stimulus queues expected outputs per cycle, a monitor checks them.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_tick;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        gnt_a, gnt_b;
  logic [3:0]  sel, digit;
  logic        blank;

`ifdef SEG_LZ_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif

  seg_display_arbiter #(.HOLD_TICKS(4)) dut (
    .clk(clk), .reset(reset), .scan_tick(scan_tick),
    .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .digit(digit), .blank(blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic       ga;
    logic       gb;
    logic [3:0] sel;
    logic [3:0] dig;
    logic       bl;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every cycle check grant exclusivity, then retire any expectation due this cycle.
  always @(negedge clk) begin
    ntests = ntests + 1;
    if (gnt_a === 1'b1 && gnt_b === 1'b1) begin
      nfail = nfail + 1;
      $display("FAIL excl cyc=%0d: gnt_a=%b gnt_b=%b, required not both 1", cyc, gnt_a, gnt_b);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ntests = ntests + 1;
      if (e.cyc < cyc) begin
        nfail = nfail + 1;
        $display("FAIL %s: expectation for cyc %0d not checked in time (now %0d)", e.name, e.cyc, cyc);
      end else if (gnt_a !== e.ga || gnt_b !== e.gb || sel !== e.sel || digit !== e.dig || blank !== e.bl) begin
        nfail = nfail + 1;
        $display("FAIL %s: got gnt_a=%b gnt_b=%b sel=%b digit=%h blank=%b, required gnt_a=%b gnt_b=%b sel=%b digit=%h blank=%b",
                 e.name, gnt_a, gnt_b, sel, digit, blank, e.ga, e.gb, e.sel, e.dig, e.bl);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_settle();
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    step(1);
  endtask

  task automatic expect_out(input string name, input logic ga, input logic gb,
                            input logic [3:0] s, input logic [3:0] d, input logic b);
    exp_t x;
    x.cyc = cyc; x.name = name; x.ga = ga; x.gb = gb; x.sel = s; x.dig = d; x.bl = b;
    q.push_back(x);
  endtask

  initial begin
    reset = 1'b1; scan_tick = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = 16'h0000; data_b = 16'h0000;
    step(2);
    expect_out("reset_state", 0, 0, 4'b0000, 4'h0, 1);
    reset = 1'b0;

    // A alone, full scan of 12AB
    data_a = 16'h12AB; req_a = 1'b1;
    step(1);       expect_out("grant_a", 1, 0, 4'b1000, 4'h1, 0);
    tick_settle(); expect_out("scan1",   1, 0, 4'b0100, 4'h2, 0);
    tick_settle(); expect_out("scan2",   1, 0, 4'b0010, 4'hA, 0);
    tick_settle(); expect_out("scan3",   1, 0, 4'b0001, 4'hB, 0);
    tick_settle(); expect_out("wrap",    1, 0, 4'b1000, 4'h1, 0);

    // A drops with B idle; counter keeps running in IDLE
    req_a = 1'b0;
    step(1);       expect_out("a_drop_idle", 0, 0, 4'b0000, 4'h0, 1);
    tick_settle();
    tick_settle(); expect_out("idle_scan",   0, 0, 4'b0000, 4'h0, 1);
    data_b = 16'h3456; req_b = 1'b1;
    step(1);       expect_out("grant_b_scan2", 0, 1, 4'b0010, 4'h5, 0);

    // Async reset mid-ownership, checked before any further clock edge
    step(1);
    expect_out("rst_async", 0, 0, 4'b0000, 4'h0, 1);
    reset = 1'b1; req_b = 1'b0;
    step(1);
    reset = 1'b0;
    expect_out("rst_release", 0, 0, 4'b0000, 4'h0, 1);

    // Ties and handover
    data_a = 16'hC0DE; req_a = 1'b1; req_b = 1'b1;
    step(1); expect_out("tie_a",       1, 0, 4'b1000, 4'hC, 0);
    req_a = 1'b0;
    step(1); expect_out("a_drop_b",    0, 1, 4'b1000, 4'h3, 0);
    req_b = 1'b0;
    step(1); expect_out("b_drop_idle", 0, 0, 4'b0000, 4'h0, 1);
    req_a = 1'b1; req_b = 1'b1;
    step(1); expect_out("tie2_a",      1, 0, 4'b1000, 4'hC, 0);

    // Hold time: B requests after one tick, preempts only once hold reaches 4
    req_b = 1'b0;
    tick_settle(); expect_out("hold1", 1, 0, 4'b0100, 4'h0, 0);
    req_b = 1'b1;
    tick_settle(); expect_out("hold2", 1, 0, 4'b0010, 4'hD, 0);
    tick_settle(); expect_out("hold3", 1, 0, 4'b0001, 4'hE, 0);
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    expect_out("hold4_still_a", 1, 0, 4'b0001, 4'hE, 0);
    step(1); expect_out("preempt_b",     0, 1, 4'b1000, 4'h3, 0);

    // Leading-zero blanking on 0005
    data_a = 16'h0005; req_b = 1'b0;
    step(1);       expect_out("lz0", 1, 0, 4'b1000, 4'h0, LZ);
    tick_settle(); expect_out("lz1", 1, 0, 4'b0100, 4'h0, LZ);
    tick_settle(); expect_out("lz2", 1, 0, 4'b0010, 4'h0, LZ);
    tick_settle(); expect_out("lz3", 1, 0, 4'b0001, 4'h5, 0);
    data_a = 16'h000F;
    step(1);       expect_out("live_data", 1, 0, 4'b0001, 4'hF, 0);

    // scan_tick coinciding with a switch uses the new owner's data
    data_b = 16'h789A; req_a = 1'b0; req_b = 1'b1; scan_tick = 1'b1;
    step(1); expect_out("switch_tick",      0, 1, 4'b0001, 4'hA, 0);
    scan_tick = 1'b0;
    step(1); expect_out("switch_tick_next", 0, 1, 4'b1000, 4'h7, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      ntests = ntests + 1;
      nfail  = nfail + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 256: minimum scan_tick count an owner keeps the display before it can be preempted; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scan_tick  input  1  one-clk-wide scan enable pulse (nominally 1 kHz).
REQ-005 SHALL have ports req_a / req_b  input  1  display requests, level-sensitive.
REQ-006 SHALL have ports data_a / data_b  input  16  four hex nibbles per requester; [15:12] is the leftmost digit.
REQ-007 SHALL have ports gnt_a / gnt_b  output  1  registered grants, mutually exclusive.
REQ-008 SHALL have port sel  output  4  one-hot digit select, registered; 4'b0000 = display off.
REQ-009 SHALL have port digit  output  4  hex nibble for the selected digit, registered; feeds an external hex-to-segment decoder.
REQ-010 SHALL have port blank  output  1  registered; 1 = the selected digit is to be shown dark.

Function
REQ-011 SHALL implement FSM states IDLE, OWN_A and OWN_B; gnt_a=1 only in OWN_A, gnt_b=1 only in OWN_B.
REQ-012 IDLE: req_a only -> OWN_A; req_b only -> OWN_B; both -> the requester that is not last_owner; neither -> stay.
REQ-013 last_owner SHALL record the most recent owner; on reset it is B, so A wins the first tie.
REQ-014 SHALL clear hold_cnt on every state entry; while in OWN_x, each scan_tick increments it, saturating at HOLD_TICKS.
REQ-015 OWN_x, owner drops req: other requesting -> OWN_other; otherwise -> IDLE. Takes effect next clk regardless of hold_cnt.
REQ-016 OWN_x, owner still requesting: if hold_cnt == HOLD_TICKS and the other requests -> OWN_other; otherwise stay.
REQ-017 Grant change SHALL take effect one clk after the deciding edge; a switch SHALL never pass through IDLE.
REQ-018 A 2-bit scan counter SHALL advance by one on each scan_tick, wrapping 3 -> 0, and SHALL run in every state.
REQ-019 Scan counter 0/1/2/3 SHALL map to sel 1000/0100/0010/0001 and to owner data nibbles [15:12]/[11:8]/[7:4]/[3:0].
REQ-020 sel and digit SHALL be registered; they reflect the scan counter and owner data one clk after they change. Owner data SHALL be sampled live, not latched at grant.
REQ-021 In IDLE: sel=4'b0000, digit=4'h0, blank=1.
REQ-022 scan_tick coinciding with a state transition: the counter still advances, and the output uses the new owner's data.

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, gnt_a=gnt_b=0, sel=4'b0000, digit=4'h0, blank=1, scan counter=0, hold_cnt=0 and last_owner=B.
REQ-024 Reset asserted mid-ownership SHALL abort the ownership; after release, arbitration restarts from IDLE at the next posedge.

Configuration
REQ-025 Macro SEG_LZ_BLANK_EN defined: while owned, blank=1 for a leading-zero digit. Digit 3 is blanked if [15:12]==0. Digit 2 is blanked if [15:8]==0. Digit 1 is blanked if [15:4]==0. Digit 0 is never blanked.
REQ-026 Macro SEG_LZ_BLANK_EN undefined: blank=0 in OWN_A and OWN_B, and blank=1 only in IDLE. Port list SHALL be identical in both builds.

Verification
REQ-027 Reset released, req_a=1, data_a=16'h12AB, four scan_ticks -> gnt_a=1 after 1 clk; sel sequence 1000,0100,0010,0001; digit 1,2,A,B; blank=0.
REQ-028 From IDLE, req_a and req_b rise in the same clk -> gnt_a=1 first. After A drops req, gnt_b=1 the next clk, and the next simultaneous tie goes to A.
REQ-029 HOLD_TICKS=4, A owns, req_b rises after 1 tick -> gnt_a stays 1 until the 4th tick, then gnt_b=1 one clk later; gnt_a and gnt_b are never both 1.
REQ-030 reset pulsed while OWN_B mid-scan (sel=0010) -> sel=0000, gnt_b=0 and blank=1 immediately, without waiting for a clk edge.
REQ-031 With SEG_LZ_BLANK_EN, data_a=16'h0005 -> blank=1,1,1,0 across sel 1000..0001. Without the macro -> blank=0 on all four digits.
REQ-032 A owns with req_b=0, A drops req -> IDLE next clk, sel=0000; scan counter keeps advancing on scan_tick.
